// File: rtl/bgr_startup_ctrl.sv
// Start-up sequencer for the bandgap reference: kicks the core, blanks while it
// settles, then confirms vbg_ok through a synchroniser and glitch filter.
module bgr_startup_ctrl #(
    parameter int PULSE_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3,
    parameter int FILTER_LEN     = 4,
    parameter int CNT_W          = 13
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       vbg_ok_i,
    output logic       porst_o,
    output logic       bgr_ready_o,
    output logic       bgr_fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KICK   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        READY  = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FILT_LAST    = FCNT_W'(FILTER_LEN - 1);
    localparam logic [1:0]        RETRY_MAX    = 2'(MAX_RETRIES);

    logic              sync1_q;
    logic              sync2_q;
    logic              okf_q;
    logic              okf_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;

    state_t            state_q;
    logic [CNT_W-1:0]  timer_q;
    logic [1:0]        retry_q;
    logic              porst_q;
    logic              ready_q;
    logic              fail_q;
    logic              canRetry;

    // Filter counts consecutive synced samples that disagree with ok_f.
    always_comb begin
        okf_d  = okf_q;
        fcnt_d = '0;
        if (sync2_q != okf_q) begin
            if (fcnt_q == FILT_LAST) begin
                okf_d = ~okf_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            okf_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            sync1_q <= vbg_ok_i;
            sync2_q <= sync1_q;
            okf_q   <= okf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign canRetry = (retry_q < RETRY_MAX);

    // Outputs are updated together with the state so they always match it.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= 2'd0;
            porst_q <= 1'b0;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= KICK;
                    timer_q <= '0;
                    porst_q <= 1'b1;
                end
                KICK: begin
                    if (timer_q == PULSE_LAST) begin
                        state_q <= SETTLE;
                        timer_q <= '0;
                        porst_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_q <= CHECK;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (okf_q) begin
                        state_q <= READY;
                        timer_q <= '0;
                        ready_q <= 1'b1;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_q <= '0;
                        if (canRetry) begin
                            state_q <= KICK;
                            porst_q <= 1'b1;
                            retry_q <= retry_q + 2'd1;
                        end else begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                READY: begin
                    if (!okf_q) begin
                        timer_q <= '0;
                        ready_q <= 1'b0;
                        if (canRetry) begin
                            state_q <= KICK;
                            porst_q <= 1'b1;
                            retry_q <= retry_q + 2'd1;
                        end else begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                        end
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    porst_q <= 1'b0;
                    ready_q <= 1'b0;
                    fail_q  <= 1'b0;
                end
            endcase
        end
    end

    assign porst_o     = porst_q;
    assign bgr_ready_o = ready_q;
    assign bgr_fail_o  = fail_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule
